// File: rtl/user_rom_arb_pkg.sv
// Shared types and constants for the user-domain ROM arbiter.
// Optional feature macro: USER_ROM_ARB_LOCK_EN (grant-lock support).
package user_rom_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

   localparam int MaxLockBeats = 16;
   localparam int LockCntWidth = $clog2(MaxLockBeats);

endpackage

// File: rtl/user_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i,
// wrapping around; returns a one-hot grant and the winning index.
module user_rr_pick import user_rom_arb_pkg::*; #(
   parameter int NumReq   = 2,
   parameter int PtrWidth = $clog2(NumReq)
) (
   input  logic [NumReq-1:0]   req_i,
   input  logic [PtrWidth-1:0] ptr_i,
   output logic [NumReq-1:0]   gnt_o,
   output logic [PtrWidth-1:0] idx_o
);

   int j;

   // Walk offsets from the farthest down to zero so the nearest request wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      j     = 0;
      for (int k = NumReq - 1; k >= 0; k--) begin
         j = int'(ptr_i) + k;
         if (j >= NumReq) j = j - NumReq;
         if (req_i[j]) begin
            gnt_o    = '0;
            gnt_o[j] = 1'b1;
            idx_o    = PtrWidth'(j);
         end
      end
   end

endmodule

// File: rtl/user_rom_arbiter.sv
// Round-robin arbiter sharing one ROM port between NumReq requesters, one
// transaction in flight. Macro USER_ROM_ARB_LOCK_EN enables grant locking.
module user_rom_arbiter import user_rom_arb_pkg::*; #(
   parameter int NumReq    = 2,
   parameter int AddrWidth = 32,
   parameter int DataWidth = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NumReq-1:0]           req_i,
   input  logic [NumReq*AddrWidth-1:0] addr_i,
   input  logic [NumReq-1:0]           lock_i,
   output logic [DataWidth-1:0]        data_o,
   output logic [NumReq-1:0]           valid_o,
   output logic                        rom_req_o,
   output logic [AddrWidth-1:0]        rom_addr_o,
   input  logic [DataWidth-1:0]        rom_data_i,
   input  logic                        rom_valid_i,
   output logic                        busy_o
);

   localparam int PtrWidth = $clog2(NumReq);

   // Handshake: a requester holds req_i (and a stable addr_i) until its
   // valid_o bit pulses; valid_o is a single-cycle pulse aligned with
   // rom_valid_i, and rom_valid_i is only honoured while BUSY.

   arb_state_e            state_q, state_d;
   logic [PtrWidth-1:0]   ptr_q, ptr_d;
   logic [PtrWidth-1:0]   owner_q, owner_d;
   logic [AddrWidth-1:0]  addr_q, addr_d;
   logic [NumReq-1:0]     pick_gnt;
   logic [PtrWidth-1:0]   pick_idx;
   logic [PtrWidth-1:0]   ptr_next;

   user_rr_pick #(
      .NumReq   (NumReq),
      .PtrWidth (PtrWidth)
   ) u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   assign ptr_next = (owner_q == PtrWidth'(NumReq - 1)) ? '0 : owner_q + 1'b1;

`ifdef USER_ROM_ARB_LOCK_EN
   logic [LockCntWidth-1:0] lock_cnt_q, lock_cnt_d;
`else
   logic unused_lock;
   assign unused_lock = ^lock_i;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      rom_req_o = 1'b0;
      busy_o    = 1'b0;
      valid_o   = '0;
      data_o    = '0;
`ifdef USER_ROM_ARB_LOCK_EN
      lock_cnt_d = lock_cnt_q;
`endif
      case (state_q)
         ARB_IDLE: begin
            if (|pick_gnt) begin
               owner_d = pick_idx;
               addr_d  = addr_i[pick_idx*AddrWidth +: AddrWidth];
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            rom_req_o = 1'b1;
            busy_o    = 1'b1;
            if (rom_valid_i) begin
               valid_o[owner_q] = 1'b1;
               data_o           = rom_data_i;
               state_d          = ARB_IDLE;
               ptr_d            = ptr_next;
`ifdef USER_ROM_ARB_LOCK_EN
               // Parking the pointer on the owner gives it first pick next IDLE.
               if (lock_i[owner_q] &&
                   (lock_cnt_q != LockCntWidth'(MaxLockBeats - 1))) begin
                  ptr_d      = owner_q;
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end else begin
                  lock_cnt_d = '0;
               end
`endif
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
      end
   end

`ifdef USER_ROM_ARB_LOCK_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lock_cnt_q <= '0;
      else         lock_cnt_q <= lock_cnt_d;
   end
`endif

   assign rom_addr_o = addr_q;

endmodule

// File: tb/tb_user_rom_arbiter.sv
// Directed self-checking bench for user_rom_arbiter (lock scenario runs only
// when USER_ROM_ARB_LOCK_EN is defined).
module tb_user_rom_arbiter;

   localparam int NumReq    = 2;
   localparam int AddrWidth = 32;
   localparam int DataWidth = 8;

   logic                        clk;
   logic                        rst_n;
   logic [NumReq-1:0]           req;
   logic [NumReq*AddrWidth-1:0] addr;
   logic [NumReq-1:0]           lock;
   logic [DataWidth-1:0]        data_o;
   logic [NumReq-1:0]           valid_o;
   logic                        rom_req_o;
   logic [AddrWidth-1:0]        rom_addr_o;
   logic [DataWidth-1:0]        rom_data;
   logic                        rom_valid;
   logic                        busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   user_rom_arbiter #(
      .NumReq    (NumReq),
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_i       (req),
      .addr_i      (addr),
      .lock_i      (lock),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .rom_req_o   (rom_req_o),
      .rom_addr_o  (rom_addr_o),
      .rom_data_i  (rom_data),
      .rom_valid_i (rom_valid),
      .busy_o      (busy_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      rst_n     = 1'b0;
      req       = '0;
      addr      = '0;
      lock      = '0;
      rom_valid = 1'b0;
      rom_data  = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_rom_req(output int cycles);
      cycles = 0;
      while (cycles < 20) begin
         @(negedge clk);
         cycles++;
         if (rom_req_o) break;
      end
      n_checks++;
      if (rom_req_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rom_req_timeout: rom_req_o=%b after %0d cycles, required 1", rom_req_o, cycles);
      end
   endtask

   task automatic rom_respond(input int delay, input logic [DataWidth-1:0] d,
                              output logic [NumReq-1:0] v, output logic [DataWidth-1:0] dout);
      repeat (delay) @(posedge clk);
      #1 rom_valid = 1'b1;
      rom_data = d;
      @(negedge clk);
      v    = valid_o;
      dout = data_o;
      @(posedge clk);
      #1 rom_valid = 1'b0;
      rom_data = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      req = '0; addr = '0; lock = '0; rom_valid = 1'b0; rom_data = '0;
      #3;
      n_checks++;
      if ({data_o, valid_o, rom_req_o, rom_addr_o, busy_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: data=%h valid=%b rom_req=%b addr=%h busy=%b, required all 0",
                  data_o, valid_o, rom_req_o, rom_addr_o, busy_o);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({rom_req_o, busy_o, valid_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_release_idle: rom_req=%b busy=%b valid=%b, required 0",
                  rom_req_o, busy_o, valid_o);
      end
   endtask

   task automatic test_single();
      int cyc;
      logic [NumReq-1:0]    v;
      logic [DataWidth-1:0] d;
      apply_reset();
      @(posedge clk);
      #1 req = 2'b01;
      addr[0*AddrWidth +: AddrWidth] = 32'h5;
      wait_rom_req(cyc);
      n_checks++;
      if (cyc !== 2) begin
         n_fail++;
         $display("FAIL single_latency: rom_req after %0d negedges, required 2", cyc);
      end
      n_checks++;
      if (rom_addr_o !== 32'h5 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL single_addr: addr=%h busy=%b, required 00000005 1", rom_addr_o, busy_o);
      end
      rom_respond(3, 8'hA7, v, d);
      req = '0;
      n_checks++;
      if (v !== 2'b01 || d !== 8'hA7) begin
         n_fail++;
         $display("FAIL single_data: valid=%b data=%h, required 01 a7", v, d);
      end
      @(negedge clk);
      n_checks++;
      if (valid_o !== 2'b00 || data_o !== 8'h00 || rom_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_after: valid=%b data=%h rom_req=%b, required 00 00 0",
                  valid_o, data_o, rom_req_o);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [NumReq-1:0]    v;
      logic [DataWidth-1:0] d;
      logic [AddrWidth-1:0] exp_addr;
      logic [NumReq-1:0]    exp_v;
      apply_reset();
      @(posedge clk);
      #1 addr = {32'h200, 32'h100};
      req = 2'b11;
      for (int i = 0; i < 6; i++) begin
         wait_rom_req(cyc);
         exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
         exp_v    = (i % 2 == 0) ? 2'b01 : 2'b10;
         n_checks++;
         if (rom_addr_o !== exp_addr) begin
            n_fail++;
            $display("FAIL rr_grant%0d: addr=%h, required %h", i, rom_addr_o, exp_addr);
         end
         if (i > 0) begin
            n_checks++;
            if (cyc !== 2) begin
               n_fail++;
               $display("FAIL rr_gap%0d: rom_req after %0d negedges, required 2", i, cyc);
            end
         end
         rom_respond(1 + (i % 3), 8'h10 + 8'(i), v, d);
         n_checks++;
         if (v !== exp_v || d !== 8'h10 + 8'(i)) begin
            n_fail++;
            $display("FAIL rr_valid%0d: valid=%b data=%h, required %b %h", i, v, d, exp_v, 8'h10 + 8'(i));
         end
      end
      req = '0;
   endtask

   task automatic test_drop_mid_busy();
      int cyc;
      logic [NumReq-1:0]    v;
      logic [DataWidth-1:0] d;
      apply_reset();
      @(posedge clk);
      #1 req = 2'b10;
      addr[1*AddrWidth +: AddrWidth] = 32'h33;
      wait_rom_req(cyc);
      n_checks++;
      if (rom_addr_o !== 32'h33) begin
         n_fail++;
         $display("FAIL drop_addr: addr=%h, required 00000033", rom_addr_o);
      end
      @(posedge clk);
      #1 req = '0;
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (rom_req_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_hold: rom_req=%b busy=%b, required 1 1", rom_req_o, busy_o);
         end
      end
      rom_respond(1, 8'h3C, v, d);
      n_checks++;
      if (v !== 2'b10 || d !== 8'h3C) begin
         n_fail++;
         $display("FAIL drop_valid: valid=%b data=%h, required 10 3c", v, d);
      end
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (rom_req_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_idle: rom_req=%b busy=%b valid=%b, required 0 0 00",
                     rom_req_o, busy_o, valid_o);
         end
      end
   endtask

   task automatic test_stray_valid();
      apply_reset();
      @(posedge clk);
      #1 rom_valid = 1'b1;
      rom_data = 8'h5A;
      @(negedge clk);
      n_checks++;
      if (valid_o !== 2'b00 || data_o !== 8'h00 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_valid: valid=%b data=%h busy=%b, required 00 00 0", valid_o, data_o, busy_o);
      end
      @(posedge clk);
      #1 rom_valid = 1'b0;
      rom_data = '0;
      @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b0 || rom_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_state: busy=%b rom_req=%b, required 0 0", busy_o, rom_req_o);
      end
   endtask

   task automatic test_reset_mid_busy();
      int cyc;
      logic [NumReq-1:0]    v;
      logic [DataWidth-1:0] d;
      apply_reset();
      @(posedge clk);
      #1 addr = {32'h88, 32'h77};
      req = 2'b01;
      wait_rom_req(cyc);
      rom_respond(1, 8'h11, v, d);
      req = 2'b10;
      wait_rom_req(cyc);
      n_checks++;
      if (rom_addr_o !== 32'h88) begin
         n_fail++;
         $display("FAIL rst_pre_addr: addr=%h, required 00000088", rom_addr_o);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({data_o, valid_o, rom_req_o, rom_addr_o, busy_o} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_busy: data=%h valid=%b rom_req=%b addr=%h busy=%b, required all 0",
                  data_o, valid_o, rom_req_o, rom_addr_o, busy_o);
      end
      req = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 rom_valid = 1'b1;
      rom_data = 8'h99;
      @(negedge clk);
      n_checks++;
      if (valid_o !== 2'b00 || data_o !== 8'h00 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_late_valid: valid=%b data=%h busy=%b, required 00 00 0", valid_o, data_o, busy_o);
      end
      @(posedge clk);
      #1 rom_valid = 1'b0;
      rom_data = '0;
      req = 2'b11;
      wait_rom_req(cyc);
      n_checks++;
      if (rom_addr_o !== 32'h77) begin
         n_fail++;
         $display("FAIL rst_ptr_zero: addr=%h, required 00000077", rom_addr_o);
      end
      rom_respond(1, 8'h22, v, d);
      req = '0;
   endtask

`ifdef USER_ROM_ARB_LOCK_EN
   task automatic test_lock();
      int cyc;
      logic [NumReq-1:0]    v;
      logic [DataWidth-1:0] d;
      logic [AddrWidth-1:0] exp_addr;
      // 9-beat lock: lock held through beats 1..8, released for beat 9.
      apply_reset();
      @(posedge clk);
      #1 addr = {32'h20, 32'h10};
      req  = 2'b11;
      lock = 2'b01;
      for (int k = 1; k <= 10; k++) begin
         wait_rom_req(cyc);
         exp_addr = (k <= 9) ? 32'h10 : 32'h20;
         n_checks++;
         if (rom_addr_o !== exp_addr) begin
            n_fail++;
            $display("FAIL lock9_beat%0d: addr=%h, required %h", k, rom_addr_o, exp_addr);
         end
         lock[0] = (k < 9);
         rom_respond(1, 8'(k), v, d);
      end
      // 20-beat lock: capped, requester 1 gets grant 17.
      apply_reset();
      @(posedge clk);
      #1 addr = {32'h20, 32'h10};
      req  = 2'b11;
      lock = 2'b01;
      for (int k = 1; k <= 17; k++) begin
         wait_rom_req(cyc);
         exp_addr = (k <= 16) ? 32'h10 : 32'h20;
         n_checks++;
         if (rom_addr_o !== exp_addr) begin
            n_fail++;
            $display("FAIL lock20_beat%0d: addr=%h, required %h", k, rom_addr_o, exp_addr);
         end
         rom_respond(1, 8'(k), v, d);
      end
      req  = '0;
      lock = '0;
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_drop_mid_busy();
      test_stray_valid();
      test_reset_mid_busy();
`ifdef USER_ROM_ARB_LOCK_EN
      test_lock();
`endif
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
